// File: rtl/demux2x4_pingpong_pkg.sv
// Shared constants and types for the ping-pong demultiplexer.
//   WIDTH_DEF : default data word width
//   N_LANES   : number of output lanes (only 2 is supported)
//   CNT_W     : width of the per-lane delivered-word counters
//   lane_t    : lane index type
package demux2x4_pingpong_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned N_LANES   = 2;
  localparam int unsigned CNT_W     = 8;

  typedef logic lane_t;

  // Round-robin successor of a lane index.
  function automatic lane_t next_lane(input lane_t cur, input int unsigned nlanes);
    if (cur == lane_t'(nlanes - 1)) begin
      return lane_t'(0);
    end
    return lane_t'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/demux2x4_pingpong_if.sv
// Handshake bundle for the ping-pong demultiplexer.
//   I/I_valid/I_ready           : upstream word offer and acceptance
//   Ok/Ok_valid/Ok_ready (k=0,1): per-lane output words and handshakes
//   sel                         : lane receiving the next accepted word
//   count0/count1               : words delivered per lane, modulo 256
// slave is the demultiplexer's view, master the surrounding logic's view.
interface demux2x4_pingpong_if
  import demux2x4_pingpong_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O0;
  logic [WIDTH-1:0] O1;
  logic             O0_valid;
  logic             O1_valid;
  logic             O0_ready;
  logic             O1_ready;
  lane_t            sel;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  modport slave (
    input  I, I_valid, O0_ready, O1_ready,
    output I_ready, O0, O1, O0_valid, O1_valid, sel, count0, count1
  );

  modport master (
    output I, I_valid, O0_ready, O1_ready,
    input  I_ready, O0, O1, O0_valid, O1_valid, sel, count0, count1
  );

endinterface

// File: rtl/demux2x4_pingpong_lane_reg.sv
// One output lane: a single data register with full flag, plus a counter of
// words handed downstream.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture din this edge (lane becomes/stays full)
//   din      : word to capture
//   ready    : downstream consumes the held word this edge
//   data     : held word
//   valid    : lane full flag
//   count    : delivered words, wraps at 2**CNT_W
module demux2x4_pingpong_lane_reg
  import demux2x4_pingpong_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic xfer;

  assign xfer = valid & ready;

  // A load wins over a drain, so a simultaneous consume-and-refill keeps the
  // lane full with the new word; data is untouched otherwise (stable stall).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

  // Delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (xfer) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux2x4_pingpong.sv
// Round-robin 1-to-2 demultiplexer with one register per lane.
//   CLK, ASYNCRESET : clock, asynchronous active-high reset
//   bus             : handshake bundle (slave view), see demux2x4_pingpong_if
// Accepted words alternate lane 0, lane 1, ... regardless of stalls; I_ready
// follows only the currently selected lane.
module demux2x4_pingpong
  import demux2x4_pingpong_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned NLANES = N_LANES
) (
  input  logic                CLK,
  input  logic                ASYNCRESET,
  demux2x4_pingpong_if.slave  bus
);

  logic [NLANES-1:0] full_v;
  logic [NLANES-1:0] ready_v;
  logic              i_ready_c;
  logic              in_xfer;
  lane_t             sel_q;

  assign full_v  = {bus.O1_valid, bus.O0_valid};
  assign ready_v = {bus.O1_ready, bus.O0_ready};

  // Selected lane can take a word when empty or draining this same edge.
  assign i_ready_c   = ~ASYNCRESET & (~full_v[sel_q] | ready_v[sel_q]);
  assign in_xfer     = bus.I_valid & i_ready_c;
  assign bus.I_ready = i_ready_c;
  assign bus.sel     = sel_q;

  // Lane pointer advances on every accepted word and only then.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      sel_q <= lane_t'(0);
    end else if (in_xfer) begin
      sel_q <= next_lane(sel_q, NLANES);
    end
  end

  demux2x4_pingpong_lane_reg #(.WIDTH(WIDTH)) u_lane0 (
    .clk   (CLK),
    .rst   (ASYNCRESET),
    .load  (in_xfer & (sel_q == lane_t'(0))),
    .din   (bus.I),
    .ready (bus.O0_ready),
    .data  (bus.O0),
    .valid (bus.O0_valid),
    .count (bus.count0)
  );

  demux2x4_pingpong_lane_reg #(.WIDTH(WIDTH)) u_lane1 (
    .clk   (CLK),
    .rst   (ASYNCRESET),
    .load  (in_xfer & (sel_q == lane_t'(1))),
    .din   (bus.I),
    .ready (bus.O1_ready),
    .data  (bus.O1),
    .valid (bus.O1_valid),
    .count (bus.count1)
  );

endmodule

// File: tb/tb_demux2x4_pingpong.sv
// Self-checking bench for demux2x4_pingpong: directed scenarios plus random
// traffic, checked against a per-lane queue model of round-robin delivery.
module tb_demux2x4_pingpong;

  localparam int unsigned W = 4;

  logic CLK;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic last_irdy;

  // Reference model: each lane is a queue of words owed downstream.
  logic [W-1:0] lane_q [2][$];
  int           m_sel;
  int           m_cnt [2];

  demux2x4_pingpong_if #(.WIDTH(W)) bus ();

  demux2x4_pingpong #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .ASYNCRESET (rst),
    .bus        (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    lane_q[0].delete();
    lane_q[1].delete();
    m_sel    = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Assert reset between edges, check cleared outputs, release at a negedge.
  task automatic do_reset();
    rst          = 1'b1;
    bus.I_valid  = 1'b0;
    bus.I        = '0;
    bus.O0_ready = 1'b0;
    bus.O1_ready = 1'b0;
    #1;
    chk("rst_o0_valid", 32'(bus.O0_valid), 0);
    chk("rst_o1_valid", 32'(bus.O1_valid), 0);
    chk("rst_o0",       32'(bus.O0), 0);
    chk("rst_o1",       32'(bus.O1), 0);
    chk("rst_sel",      32'(bus.sel), 0);
    chk("rst_count0",   32'(bus.count0), 0);
    chk("rst_count1",   32'(bus.count1), 0);
    chk("rst_i_ready",  32'(bus.I_ready), 0);
    model_clear();
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
  endtask

  // One cycle: drive, compare with model, clock, advance model.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic r0, input logic r1);
    logic   exp_rdy;
    logic   in_x;
    logic   lx [2];
    logic   rr [2];
    int     s;
    bus.I_valid  = iv;
    bus.I        = d;
    bus.O0_ready = r0;
    bus.O1_ready = r1;
    rr[0] = r0;
    rr[1] = r1;
    #1;
    s       = m_sel;
    exp_rdy = (lane_q[s].size() == 0) || rr[s];
    chk("o0_valid", 32'(bus.O0_valid), 32'(lane_q[0].size() != 0));
    chk("o1_valid", 32'(bus.O1_valid), 32'(lane_q[1].size() != 0));
    if (lane_q[0].size() != 0) chk("o0_data", 32'(bus.O0), 32'(lane_q[0][0]));
    if (lane_q[1].size() != 0) chk("o1_data", 32'(bus.O1), 32'(lane_q[1][0]));
    chk("sel",     32'(bus.sel), 32'(s));
    chk("count0",  32'(bus.count0), 32'(m_cnt[0]));
    chk("count1",  32'(bus.count1), 32'(m_cnt[1]));
    chk("i_ready", 32'(bus.I_ready), 32'(exp_rdy));
    last_irdy = bus.I_ready;
    in_x  = iv && exp_rdy;
    lx[0] = (lane_q[0].size() != 0) && r0;
    lx[1] = (lane_q[1].size() != 0) && r1;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (lx[k]) begin
        void'(lane_q[k].pop_front());
        m_cnt[k] = (m_cnt[k] + 1) % 256;
      end
    end
    if (in_x) begin
      lane_q[s].push_back(d);
      m_sel = 1 - s;
    end
    @(negedge CLK);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    last_irdy    = 1'b0;
    rst          = 1'b1;
    bus.I_valid  = 1'b0;
    bus.I        = '0;
    bus.O0_ready = 1'b0;
    bus.O1_ready = 1'b0;
    model_clear();
    @(negedge CLK);
    do_reset();

    // Back-to-back words, both lanes ready.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b1);
      chk("b2b_i_ready", 32'(last_irdy), 1);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("b2b_count0", 32'(bus.count0), 2);
    chk("b2b_count1", 32'(bus.count1), 2);

    // Lane 1 stalled.
    do_reset();
    step(1'b1, W'(4'hA), 1'b1, 1'b0);
    step(1'b1, W'(4'hB), 1'b1, 1'b0);
    step(1'b1, W'(4'hC), 1'b1, 1'b0);
    chk("stall_c_acc", 32'(last_irdy), 1);
    step(1'b1, W'(4'hD), 1'b1, 1'b0);
    chk("stall_d_blk", 32'(last_irdy), 0);
    chk("stall_o1_hold", 32'(bus.O1), 32'hB);
    chk("stall_o1_valid", 32'(bus.O1_valid), 1);
    step(1'b1, W'(4'hD), 1'b1, 1'b1);
    chk("stall_d_acc", 32'(last_irdy), 1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Refill a full lane while it drains.
    do_reset();
    step(1'b1, W'(4'h9), 1'b0, 1'b0);
    step(1'b1, W'(4'h1), 1'b0, 1'b1);
    step(1'b1, W'(4'h5), 1'b1, 1'b1);
    chk("pass_i_ready", 32'(last_irdy), 1);
    chk("pass_o0", 32'(bus.O0), 32'h5);
    chk("pass_o0_valid", 32'(bus.O0_valid), 1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Counter wrap: 512 accepted words.
    do_reset();
    for (int i = 0; i < 512; i++) step(1'b1, W'(i), 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("wrap_count0", 32'(bus.count0), 0);
    chk("wrap_count1", 32'(bus.count1), 0);

    // Reset mid-operation with both lanes full.
    do_reset();
    step(1'b1, W'(4'h3), 1'b0, 1'b0);
    step(1'b1, W'(4'h4), 1'b0, 1'b0);
    chk("mid_full0", 32'(bus.O0_valid), 1);
    chk("mid_full1", 32'(bus.O1_valid), 1);
    #2;
    do_reset();
    step(1'b1, W'(4'h7), 1'b0, 1'b0);
    chk("mid_next_o0", 32'(bus.O0), 32'h7);
    chk("mid_next_valid", 32'(bus.O0_valid), 1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      step(logic'($urandom_range(0, 3) != 0), W'($urandom),
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 2) != 0));
    end
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("rand_drained0", 32'(bus.O0_valid), 0);
    chk("rand_drained1", 32'(bus.O1_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux2x4_pingpong.md
DEMUX2X4_PINGPONG -- requirements
Module: demux2x4_pingpong

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits.
REQ-002 Parameter NLANES, fixed at 2: number of output lanes; other values are not supported.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 ASYNCRESET  input  1  asynchronous, active-high reset.
REQ-005 I  input  WIDTH  input data word.
REQ-006 I_valid  input  1  I holds a word offered for transfer.
REQ-007 I_ready  output  1  block accepts I this cycle.
REQ-008 O0, O1  output  WIDTH each  lane 0 and lane 1 data.
REQ-009 O0_valid, O1_valid  output  1 each  lane holds a word.
REQ-010 O0_ready, O1_ready  input  1 each  downstream consumes the lane word this cycle.
REQ-011 sel  output  1  lane index that receives the next accepted word.
REQ-012 count0, count1  output  8 each  words delivered per lane, modulo 256.

Function
REQ-013 Input transfer = I_valid and I_ready high in the same rising edge; lane transfer k = Ok_valid and Ok_ready high in the same rising edge.
REQ-014 Words SHALL be distributed strictly round-robin: 1st accepted word to lane 0, 2nd to lane 1, 3rd to lane 0, and so on; no skipping when a lane is stalled.
REQ-015 Each lane SHALL hold one register (data + full flag); Ok_valid equals that lane's full flag.
REQ-016 I_ready SHALL be high exactly when the lane selected by sel is empty or is transferring in the same cycle (combinational pass-through of Ok_ready to I_ready only for the selected lane).
REQ-017 On input transfer, the word SHALL load into lane sel at that edge and become visible on O<sel> with O<sel>_valid high in the next cycle (latency 1).
REQ-018 sel SHALL toggle on every input transfer and only then.
REQ-019 Simultaneous input transfer into lane k and lane k transfer: the lane SHALL stay full, holding the new word; no bubble, no loss.
REQ-020 Lane transfer without a load into that lane: the lane SHALL become empty at that edge.
REQ-021 Ok and Ok_valid SHALL NOT change while Ok_valid is high and Ok_ready is low.
REQ-022 countk SHALL increment by 1 on each lane-k transfer and wrap 255 -> 0.
REQ-023 I_ready SHALL NOT depend on the non-selected lane's state.
REQ-024 With I_valid low, lanes SHALL drain independently; sel is unchanged.

Reset
REQ-025 While ASYNCRESET is high: O0_valid = O1_valid = 0, O0 = O1 = 0, sel = 0, count0 = count1 = 0, regardless of CLK.
REQ-026 Reset asserted mid-operation SHALL discard held words immediately; after deassertion the next accepted word goes to lane 0.
REQ-027 I_ready SHALL be low while ASYNCRESET is high.

Structure
REQ-028 WIDTH default, NLANES and the count width (8) SHALL be constants in the shared package alongside the lane-index type.
REQ-029 The per-lane register plus counter SHALL be one sub-module, lane_reg, instantiated twice; the top holds sel and the I_ready steering.

Verification
REQ-030 Reset then words 0x1,0x2,0x3,0x4 back-to-back with both lanes ready -> O0 shows 0x1 then 0x3, O1 shows 0x2 then 0x4, each one cycle after acceptance; I_ready stays 1; count0 = count1 = 2.
REQ-031 O1_ready held 0 after loading 0xA (lane 0) and 0xB (lane 1); offer 0xC -> accepted (goes to lane 0 after it drains); offer 0xD -> I_ready 0 and O1 held at 0xB while stalled; raise O1_ready -> 0xD accepted in that same cycle.
REQ-032 Lane 0 full and O0_ready = 1 with sel = 0 and I_valid = 1 (I = 0x5) -> I_ready 1, O0 = 0x5 next cycle, O0_valid stays 1.
REQ-033 Deliver 256 words to lane 0 (512 total accepted) -> count0 wraps to 0, count1 = 0 (also wrapped).
REQ-034 Assert ASYNCRESET between clock edges with both lanes full -> O0_valid, O1_valid, sel and counts 0 immediately; next word 0x7 appears on O0.
REQ-035 Random I_valid and Ok_ready for 10k cycles -> per-lane output order matches reference round-robin model, no loss or duplication.
